// File: rtl/fb_pkg.sv
// Shared framebuffer constants, fill FSM state type and a constant-multiply helper.
package fb_pkg;

   localparam int unsigned FB_H           = 640;
   localparam int unsigned FB_V           = 480;
   localparam int unsigned FB_PIXEL_COUNT = FB_H * FB_V;
   localparam int unsigned FB_FAIR_LIMIT  = 8;

   typedef enum logic [1:0] {
      FILL_IDLE,
      FILL_SETUP,
      FILL_RUN,
      FILL_DONE
   } fill_state_e;

   // k is an elaboration constant, so this collapses to shifted adds
   function automatic logic [31:0] mul_const(input logic [31:0] a,
                                             input logic [31:0] k);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) begin
         if (k[i]) acc = acc + (a << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/fb_write_arb_if.sv
// CPU write handshake and framebuffer write port.
interface fb_write_arb_if;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_ack;
   logic        vmem_wr;
   logic [31:0] vmem_addr;
   logic [7:0]  vmem_data;

   modport master (
      output cpu_req, cpu_addr, cpu_data,
      input  cpu_ack, vmem_wr, vmem_addr, vmem_data
   );

   modport slave (
      input  cpu_req, cpu_addr, cpu_data,
      output cpu_ack, vmem_wr, vmem_addr, vmem_data
   );
endinterface

// File: rtl/fb_fill_gen.sv
// Rectangle fill engine: clips the rectangle and walks it row-major.
module fb_fill_gen
   import fb_pkg::*;
#(
   parameter int unsigned H = FB_H,
   parameter int unsigned V = FB_V
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [9:0]  x,
   input  logic [8:0]  y,
   input  logic [9:0]  w,
   input  logic [8:0]  h,
   input  logic [7:0]  color,
   input  logic        gnt,
   output logic        vld,
   output logic [31:0] addr,
   output logic [7:0]  data,
   output logic        busy,
   output logic        done
);

   localparam logic [31:0] HW = 32'(H);
   localparam logic [31:0] VW = 32'(V);

   fill_state_e state_q, state_d;
   logic [31:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
   logic [31:0] ew_q, ew_d, eh_q, eh_d;
   logic [31:0] col_q, col_d, row_q, row_d, base_q, base_d;
   logic [7:0]  color_q, color_d;
   logic        zero;

   assign zero = (x_q >= HW) || (y_q >= VW) ||
                 (w_q == '0) || (h_q == '0);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      color_d = color_q;
      ew_d    = ew_q;
      eh_d    = eh_q;
      col_d   = col_q;
      row_d   = row_q;
      base_d  = base_q;
      unique case (state_q)
         FILL_IDLE: begin
            if (start && !abort) begin
               x_d     = 32'(x);
               y_d     = 32'(y);
               w_d     = 32'(w);
               h_d     = 32'(h);
               color_d = color;
               col_d   = '0;
               row_d   = '0;
               state_d = FILL_SETUP;
            end
         end
         FILL_SETUP: begin
            if (abort) begin
               state_d = FILL_IDLE;
            end else begin
               // H-x / V-y only meaningful when not zero-area
               ew_d    = (w_q < HW - x_q) ? w_q : HW - x_q;
               eh_d    = (h_q < VW - y_q) ? h_q : VW - y_q;
               base_d  = mul_const(y_q, HW) + x_q;
               state_d = zero ? FILL_DONE : FILL_RUN;
            end
         end
         FILL_RUN: begin
            if (abort) begin
               state_d = FILL_IDLE;
            end else if (gnt) begin
               if (col_q == ew_q - 32'd1) begin
                  if (row_q == eh_q - 32'd1) begin
                     state_d = FILL_DONE;
                  end else begin
                     col_d  = '0;
                     row_d  = row_q + 32'd1;
                     base_d = base_q + HW;
                  end
               end else begin
                  col_d = col_q + 32'd1;
               end
            end
         end
         FILL_DONE: state_d = FILL_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
         ew_q    <= '0;
         eh_q    <= '0;
         col_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         color_q <= color_d;
         ew_q    <= ew_d;
         eh_q    <= eh_d;
         col_q   <= col_d;
         row_q   <= row_d;
         base_q  <= base_d;
      end
   end

   // base_q already carries the x offset of the rectangle
   assign vld  = (state_q == FILL_RUN) && !abort;
   assign addr = base_q + col_q;
   assign data = color_q;
   assign busy = (state_q != FILL_IDLE);
   assign done = (state_q == FILL_DONE);

endmodule

// File: rtl/fb_write_arb.sv
// Single-port framebuffer write arbiter between CPU byte writes and the fill engine.
module fb_write_arb
   import fb_pkg::*;
#(
   parameter int unsigned H           = FB_H,
   parameter int unsigned V           = FB_V,
   parameter int unsigned PIXEL_COUNT = FB_PIXEL_COUNT,
   parameter int unsigned FAIR_LIMIT  = FB_FAIR_LIMIT
) (
   input  logic         cpu_clk,
   input  logic         reset,
   fb_write_arb_if.slave bus,
   input  logic         fill_start,
   input  logic [9:0]   fill_x,
   input  logic [8:0]   fill_y,
   input  logic [9:0]   fill_w,
   input  logic [8:0]   fill_h,
   input  logic [7:0]   fill_color,
   input  logic         fill_abort,
   output logic         fill_busy,
   output logic         fill_done
);

   localparam int SW = $clog2(FAIR_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(FAIR_LIMIT);

   logic          cpu_ack_q, cpu_ack_d;
   logic          vmem_wr_q, vmem_wr_d;
   logic [31:0]   vmem_addr_q, vmem_addr_d;
   logic [7:0]    vmem_data_q, vmem_data_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          cpu_ok, fill_vld, fill_win, cpu_gnt;
   logic [31:0]   fill_addr;
   logic [7:0]    fill_data;

   fb_fill_gen #(.H(H), .V(V)) u_fill (
      .clk   (cpu_clk),
      .rst   (reset),
      .start (fill_start),
      .abort (fill_abort),
      .x     (fill_x),
      .y     (fill_y),
      .w     (fill_w),
      .h     (fill_h),
      .color (fill_color),
      .gnt   (fill_win),
      .vld   (fill_vld),
      .addr  (fill_addr),
      .data  (fill_data),
      .busy  (fill_busy),
      .done  (fill_done)
   );

   // the CPU still holds its request during the ack cycle
   assign cpu_ok   = bus.cpu_req && !cpu_ack_q;
   assign fill_win = fill_vld && (!cpu_ok || streak_q == LIM);
   assign cpu_gnt  = cpu_ok && !fill_win;

   always_comb begin
      cpu_ack_d   = cpu_gnt;
      vmem_wr_d   = 1'b0;
      vmem_addr_d = vmem_addr_q;
      vmem_data_d = vmem_data_q;
      streak_d    = streak_q;
      if (fill_win) begin
         vmem_wr_d   = 1'b1;
         vmem_addr_d = fill_addr;
         vmem_data_d = fill_data;
         streak_d    = '0;
      end else if (cpu_gnt) begin
         if (bus.cpu_addr < 32'(PIXEL_COUNT)) begin
            vmem_wr_d   = 1'b1;
            vmem_addr_d = bus.cpu_addr;
            vmem_data_d = bus.cpu_data;
         end
         if (streak_q != LIM) streak_d = streak_q + SW'(1);
      end else if (!bus.cpu_req) begin
         streak_d = '0;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         cpu_ack_q   <= 1'b0;
         vmem_wr_q   <= 1'b0;
         vmem_addr_q <= '0;
         vmem_data_q <= '0;
         streak_q    <= '0;
      end else begin
         cpu_ack_q   <= cpu_ack_d;
         vmem_wr_q   <= vmem_wr_d;
         vmem_addr_q <= vmem_addr_d;
         vmem_data_q <= vmem_data_d;
         streak_q    <= streak_d;
      end
   end

   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.vmem_wr   = vmem_wr_q;
   assign bus.vmem_addr = vmem_addr_q;
   assign bus.vmem_data = vmem_data_q;

endmodule

// File: tb/tb_fb_write_arb.sv
// Directed bench for fb_write_arb: CPU writes, fills, clipping, fairness, abort, reset.
module tb_fb_write_arb;

   logic       cpu_clk = 1'b0;
   logic       reset;
   logic       fill_start, fill_abort;
   logic [9:0] fill_x, fill_w;
   logic [8:0] fill_y, fill_h;
   logic [7:0] fill_color;
   logic       fill_busy, fill_done;

   fb_write_arb_if bus();

   fb_write_arb dut (
      .cpu_clk    (cpu_clk),
      .reset      (reset),
      .bus        (bus),
      .fill_start (fill_start),
      .fill_x     (fill_x),
      .fill_y     (fill_y),
      .fill_w     (fill_w),
      .fill_h     (fill_h),
      .fill_color (fill_color),
      .fill_abort (fill_abort),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done)
   );

   always #5 cpu_clk = ~cpu_clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] wa[$];
   logic [7:0]  wd[$];
   int acks, dones, fill_wr, run, max_run;
   int hits[100];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      wa.delete();
      wd.delete();
      acks = 0; dones = 0; fill_wr = 0; run = 0; max_run = 0;
      foreach (hits[i]) hits[i] = 0;
   endtask

   always @(negedge cpu_clk) begin
      if (bus.vmem_wr) begin
         wa.push_back(bus.vmem_addr);
         wd.push_back(bus.vmem_data);
         if (!bus.cpu_ack) begin
            int a;
            fill_wr++;
            if (run > max_run) max_run = run;
            run = 0;
            a = int'(bus.vmem_addr) - 6400;
            if (a >= 0 && a / 640 < 10 && a % 640 < 10)
               hits[(a / 640) * 10 + a % 640]++;
         end
      end
      if (bus.cpu_ack) begin
         acks++;
         if (bus.vmem_wr) run++;
      end
      if (fill_done) dones++;
   end

   task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
      bit got = 0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_data = d;
      for (int i = 0; i < 20; i++) begin
         @(posedge cpu_clk); #1;
         if (bus.cpu_ack) begin got = 1; break; end
      end
      bus.cpu_req = 1'b0;
      chk("cpu_ack_seen", 32'(got), 1);
   endtask

   task automatic start_fill(input logic [9:0] x, input logic [8:0] y,
                             input logic [9:0] w, input logic [8:0] h,
                             input logic [7:0] c);
      fill_x = x; fill_y = y; fill_w = w; fill_h = h; fill_color = c;
      fill_start = 1'b1;
      @(posedge cpu_clk); #1;
      fill_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (fill_busy && n < 2000) begin
         @(posedge cpu_clk); #1;
         n++;
      end
      chk(tag, 32'(n < 2000), 1);
      repeat (2) @(posedge cpu_clk);
      #1;
   endtask

   task automatic run_fill(input logic [9:0] x, input logic [8:0] y,
                           input logic [9:0] w, input logic [8:0] h,
                           input logic [7:0] c);
      start_fill(x, y, w, h, c);
      wait_idle("fill_timeout");
   endtask

   initial begin
      int n, k, bad, base;
      bit stop;
      reset = 1'b1;
      fill_start = 0; fill_abort = 0;
      fill_x = 0; fill_y = 0; fill_w = 0; fill_h = 0; fill_color = 0;
      bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_data = 0;
      repeat (3) @(posedge cpu_clk);
      #1;
      chk("rst_vmem_wr", 32'(bus.vmem_wr), 0);
      chk("rst_cpu_ack", 32'(bus.cpu_ack), 0);
      chk("rst_busy", 32'(fill_busy), 0);
      chk("rst_done", 32'(fill_done), 0);
      chk("rst_addr", bus.vmem_addr, 0);
      chk("rst_data", 32'(bus.vmem_data), 0);
      reset = 1'b0;
      @(posedge cpu_clk); #1;

      clr();
      cpu_write(32'h4B000, 8'h55);
      repeat (3) @(posedge cpu_clk);
      #1;
      chk("oob_acks", acks, 1);
      chk("oob_writes", wa.size(), 0);

      clr();
      cpu_write(32'h12C, 8'hA7);
      repeat (3) @(posedge cpu_clk);
      #1;
      chk("cpu_writes", wa.size(), 1);
      chk("cpu_addr", wa.size() > 0 ? wa[0] : 32'hFFFF_FFFF, 32'h12C);
      chk("cpu_data", wd.size() > 0 ? 32'(wd[0]) : 32'hFFFF, 32'hA7);

      clr();
      run_fill(10'd10, 9'd2, 10'd3, 9'd2, 8'hE0);
      chk("fill6_cnt", wa.size(), 6);
      if (wa.size() == 6) begin
         logic [31:0] ex[6] = '{1290, 1291, 1292, 1930, 1931, 1932};
         for (int i = 0; i < 6; i++) chk($sformatf("fill6_a%0d", i), wa[i], ex[i]);
         bad = 0;
         foreach (wd[i]) if (wd[i] != 8'hE0) bad++;
         chk("fill6_data", bad, 0);
      end
      chk("fill6_done", dones, 1);

      clr();
      run_fill(10'd638, 9'd479, 10'd5, 9'd5, 8'h03);
      chk("clip_cnt", wa.size(), 2);
      if (wa.size() == 2) begin
         chk("clip_a0", wa[0], 307198);
         chk("clip_a1", wa[1], 307199);
      end
      chk("clip_done", dones, 1);

      clr();
      start_fill(10'd5, 9'd5, 10'd0, 9'd4, 8'h11);
      n = 0;
      while (!fill_done && n < 10) begin
         @(posedge cpu_clk); #1;
         n++;
      end
      chk("w0_latency_ok", 32'(n <= 3), 1);
      wait_idle("w0_timeout");
      chk("w0_writes", wa.size(), 0);
      chk("w0_done", dones, 1);

      clr();
      start_fill(10'd0, 9'd100, 10'd5, 9'd1, 8'h33);
      @(posedge cpu_clk); #1;
      start_fill(10'd0, 9'd200, 10'd1, 9'd1, 8'hFF);
      wait_idle("busy_timeout");
      repeat (4) @(posedge cpu_clk);
      #1;
      chk("busy_ign_cnt", wa.size(), 5);
      if (wa.size() == 5) begin
         chk("busy_ign_a0", wa[0], 64000);
         chk("busy_ign_a4", wa[4], 64004);
      end
      chk("busy_ign_done", dones, 1);

      clr();
      start_fill(10'd100, 9'd50, 10'd20, 9'd1, 8'h44);
      k = 0; n = 0;
      while (k < 4 && n < 50) begin
         @(posedge cpu_clk); #1;
         n++;
         if (bus.vmem_wr) k++;
      end
      fill_abort = 1'b1;
      @(posedge cpu_clk); #1;
      fill_abort = 1'b0;
      chk("abort_busy", 32'(fill_busy), 0);
      repeat (5) @(posedge cpu_clk);
      #1;
      chk("abort_writes", wa.size(), 4);
      chk("abort_done", dones, 0);

      clr();
      stop = 0; k = 0;
      fork
         begin
            run_fill(10'd0, 9'd10, 10'd10, 9'd10, 8'h1C);
            stop = 1;
         end
         begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 200000;
            bus.cpu_data = 8'h00;
            for (int c = 0; c < 3000; c++) begin
               @(posedge cpu_clk); #1;
               if (bus.cpu_ack) begin
                  k++;
                  if (stop) break;
                  bus.cpu_addr = 200000 + k;
                  bus.cpu_data = 8'(k);
               end
            end
            bus.cpu_req = 1'b0;
         end
      join
      repeat (3) @(posedge cpu_clk);
      #1;
      bad = 0;
      foreach (hits[i]) if (hits[i] != 1) bad++;
      chk("fair_cover", bad, 0);
      chk("fair_fill_cnt", fill_wr, 100);
      chk("fair_run_ok", 32'(max_run <= 8), 1);
      chk("fair_cpu_active", 32'(acks > 8), 1);
      chk("fair_done", dones, 1);

      clr();
      start_fill(10'd0, 9'd300, 10'd20, 9'd1, 8'h66);
      repeat (5) @(posedge cpu_clk);
      #1;
      reset = 1'b1;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h100;
      bus.cpu_data = 8'h77;
      @(posedge cpu_clk); #1;
      reset = 1'b0;
      chk("rstmid_busy", 32'(fill_busy), 0);
      chk("rstmid_wr", 32'(bus.vmem_wr), 0);
      base = wa.size();
      n = 0;
      while (!bus.cpu_ack && n < 20) begin
         @(posedge cpu_clk); #1;
         n++;
      end
      bus.cpu_req = 1'b0;
      chk("rstmid_cpu_ack", 32'(bus.cpu_ack), 1);
      repeat (5) @(posedge cpu_clk);
      #1;
      chk("rstmid_new_wr", wa.size() - base, 1);
      chk("rstmid_addr", wa.size() > base ? wa[base] : 32'hFFFF_FFFF, 32'h100);
      chk("rstmid_done", dones, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
